// File: rtl/fix_mult.sv
// fix_mult: pipelined signed fixed-point multiplier (Q9.7 x Q2.14 -> Q11.5).
// Rounds half toward +infinity, saturates to the result width, and has one
// clock of latency.
module fix_mult #(
  parameter int WIDTHa = 16,
  parameter int WIDTHb = 16,
  parameter int WIDTHr = 16,
  parameter int FRACa  = 7,
  parameter int FRACb  = 14,
  parameter int FRACr  = 5
) (
  input  logic              clk,
  input  logic              rstn,     // active-high asynchronous reset
  input  logic              vld_in,
  input  logic [WIDTHa-1:0] a,
  input  logic [WIDTHb-1:0] b,
  output logic              vld_out,
  output logic [WIDTHr-1:0] r
);

  localparam int SHIFT = FRACa + FRACb - FRACr;
  localparam int WP    = WIDTHa + WIDTHb;
  localparam int WW    = WP + 1;
  localparam logic [WW-1:0] HALF = WW'(1) << (SHIFT - 1);

  generate
    if (SHIFT < 1) begin : g_bad_shift
      $error("fix_mult: FRACa+FRACb-FRACr must be >= 1");
    end
    if (WIDTHr >= WW) begin : g_bad_width
      $error("fix_mult: WIDTHr must be narrower than WIDTHa+WIDTHb+1");
    end
  endgenerate

  logic signed [WP-1:0]     prod;
  logic signed [WW-1:0]     sum;
  logic signed [WW-1:0]     q;
  logic [WW-WIDTHr:0]       top;
  logic                     pos_ovf;
  logic                     neg_ovf;
  logic [WIDTHr-1:0]        r_d;
  logic [WIDTHr-1:0]        r_q;
  logic                     vld_q;

  // Full product, round half-up in a one-bit-wider domain, then saturate.
  always_comb begin
    prod = $signed(a) * $signed(b);
    sum  = {prod[WP-1], prod} + HALF;
    q    = sum >>> SHIFT;
    // q fits the result iff all bits from the result sign bit upward agree.
    top     = q[WW-1:WIDTHr-1];
    pos_ovf = !q[WW-1] && (|top);
    neg_ovf =  q[WW-1] && !(&top);
    if (pos_ovf) begin
      r_d = {1'b0, {(WIDTHr-1){1'b1}}};
    end else if (neg_ovf) begin
      r_d = {1'b1, {(WIDTHr-1){1'b0}}};
    end else begin
      r_d = q[WIDTHr-1:0];
    end
  end

  // Output register: load on valid input, otherwise hold; strobe follows vld_in.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_q   <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= vld_in;
      if (vld_in) begin
        r_q <= r_d;
      end
    end
  end

  assign r       = r_q;
  assign vld_out = vld_q;

endmodule

// File: tb/tb_fix_mult.sv
// tb_fix_mult: directed corner cases plus a randomized stream checked against
// an arithmetic reference model of fix_mult with default parameters.
module tb_fix_mult;

  localparam int SHIFT = 7 + 14 - 5;

  logic        clk;
  logic        rstn;
  logic        vld_in;
  logic [15:0] a;
  logic [15:0] b;
  logic        vld_out;
  logic [15:0] r;

  int unsigned n_chk;
  int unsigned n_pass;

  fix_mult #(
    .WIDTHa(16), .WIDTHb(16), .WIDTHr(16),
    .FRACa(7), .FRACb(14), .FRACr(5)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .vld_in (vld_in),
    .a      (a),
    .b      (b),
    .vld_out(vld_out),
    .r      (r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference: exact integer product, add half an output LSB, floor-divide
  // by 2^SHIFT, clamp to the signed 16-bit range.
  function automatic logic [15:0] ref_mult(input logic [15:0] ai, input logic [15:0] bi);
    longint p;
    longint qv;
    p  = longint'($signed(ai)) * longint'($signed(bi));
    qv = (p + (longint'(1) << (SHIFT - 1))) >>> SHIFT;
    if (qv > 32767)  qv = 32767;
    if (qv < -32768) qv = -32768;
    return qv[15:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One valid operation, then one idle cycle checking the hold.
  task automatic apply(input string tag, input logic [15:0] ai, input logic [15:0] bi,
                       input logic [15:0] exp);
    vld_in = 1'b1; a = ai; b = bi;
    tick();
    chk({tag, "_vld"}, vld_out, 1);
    chk({tag, "_r"}, r, exp);
    vld_in = 1'b0; a = 16'($urandom); b = 16'($urandom);
    tick();
    chk({tag, "_vld0"}, vld_out, 0);
    chk({tag, "_hold"}, r, exp);
  endtask

  logic [15:0] sq[$];
  logic [15:0] last_r;
  logic [15:0] e;
  logic        v;
  int unsigned issued;
  int unsigned got;
  int unsigned cyc;

  initial begin
    n_chk = 0; n_pass = 0;
    rstn = 1'b1; vld_in = 1'b0; a = '0; b = '0;

    // Held in reset with activity on the inputs: outputs stay cleared.
    for (int i = 0; i < 4; i++) begin
      vld_in = i[0]; a = 16'h0080; b = 16'h4000;
      tick();
      chk("rst_vld", vld_out, 0);
      chk("rst_r", r, 16'h0000);
    end
    vld_in = 1'b0;
    rstn = 1'b0;

    apply("unity", 16'h0080, 16'h4000, 16'h0020);
    apply("neg1",  16'hFF80, 16'h4000, 16'hFFE0);
    apply("minmin",16'h8000, 16'h8000, 16'h4000);
    apply("max",   16'h7FFF, 16'h4000, 16'h2000);
    apply("tie_lo",16'h0001, 16'h4000, 16'h0000);
    apply("tie_hi",16'h0002, 16'h4000, 16'h0001);
    apply("tie_ng",16'hFFFE, 16'h4000, 16'h0000);

    // Asynchronous reset mid-cycle with a result in the output register.
    vld_in = 1'b1; a = 16'h0080; b = 16'h4000;
    @(posedge clk);
    #1;
    chk("ar_pre_vld", vld_out, 1);
    chk("ar_pre_r", r, 16'h0020);
    #2;
    rstn = 1'b1;
    #1;
    chk("ar_vld", vld_out, 0);
    chk("ar_r", r, 16'h0000);
    // Valid input while in reset is discarded.
    tick();
    chk("ar_hold_vld", vld_out, 0);
    chk("ar_hold_r", r, 16'h0000);
    rstn = 1'b0;
    vld_in = 1'b1; a = 16'hFF80; b = 16'h4000;
    tick();
    chk("ar_first_vld", vld_out, 1);
    chk("ar_first_r", r, 16'hFFE0);
    last_r = 16'hFFE0;

    // Random stream: back-to-back, then alternating, then random strobes.
    issued = 0; got = 0; cyc = 0;
    do begin
      if (cyc < 64)       v = 1'b1;
      else if (cyc < 192) v = cyc[0];
      else                v = 1'($urandom_range(0, 1));
      if (issued >= 512) v = 1'b0;
      vld_in = v;
      case ($urandom_range(0, 7))
        0:       a = 16'h8000;
        1:       a = 16'h7FFF;
        default: a = 16'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0:       b = 16'h8000;
        1:       b = 16'h4000;
        default: b = 16'($urandom);
      endcase
      if (v) begin
        sq.push_back(ref_mult(a, b));
        issued++;
      end
      tick();
      chk("s_vld", vld_out, v);
      if (vld_out) begin
        chk("s_pending", sq.size() != 0, 1);
        if (sq.size() != 0) begin
          e = sq.pop_front();
          chk("s_r", r, e);
          last_r = e;
        end
        got++;
      end else begin
        chk("s_hold", r, last_r);
      end
      cyc++;
    end while (cyc < 5000 && !(issued >= 512 && !v));

    chk("s_count", got, 512);
    chk("s_left", sq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
